// File: rtl/neorv32_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : neorv32_wb_bus_arbiter
//  Purpose  : Shares one Wishbone classic master port between the CPU
//             instruction bus (read only) and data bus. Single-cycle CPU
//             strobes are captured into per-port pending slots. Requests are
//             granted round-robin, and one Wishbone cycle runs at a time.
//             Each cycle ends with an ack, or with an err on timeout, to the
//             originating CPU port.
//  Ports    : clk, rst_n                    - clock, async active-low reset
//             ibus_stb_i/addr_i             - ibus request (read only)
//             ibus_rdata_o/ack_o/err_o      - ibus completion
//             dbus_stb_i/rw_i/addr_i/
//             dbus_wdata_i/ben_i            - dbus request
//             dbus_rdata_o/ack_o/err_o      - dbus completion
//             core_cyc_o/stb_o/we_o/wstrb_o/
//             core_addr_o/data_o            - Wishbone request (registered)
//             core_data_i/ack_i             - Wishbone response
//  Revision : 1.0 - initial release
// ============================================================================
module neorv32_wb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ibus_stb_i,
    input  logic [ADDR_WIDTH-1:0]     ibus_addr_i,
    output logic [DATA_WIDTH-1:0]     ibus_rdata_o,
    output logic                      ibus_ack_o,
    output logic                      ibus_err_o,
    input  logic                      dbus_stb_i,
    input  logic                      dbus_rw_i,
    input  logic [ADDR_WIDTH-1:0]     dbus_addr_i,
    input  logic [DATA_WIDTH-1:0]     dbus_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   dbus_ben_i,
    output logic [DATA_WIDTH-1:0]     dbus_rdata_o,
    output logic                      dbus_ack_o,
    output logic                      dbus_err_o,
    output logic                      core_cyc_o,
    output logic                      core_stb_o,
    output logic                      core_we_o,
    output logic [DATA_WIDTH/8-1:0]   core_wstrb_o,
    output logic [ADDR_WIDTH-1:0]     core_addr_o,
    output logic [DATA_WIDTH-1:0]     core_data_o,
    input  logic [DATA_WIDTH-1:0]     core_data_i,
    input  logic                      core_ack_i
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_bus  = 1'b1;

    // Counter just wide enough to hold TIMEOUT_CYCLES.
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);

    logic [0:0]              r_state;
    logic                    r_last_d;   // 1: last grant went to dbus
    logic                    r_gnt_d;    // 1: cycle in flight belongs to dbus
    logic [c_cnt_w-1:0]      r_cnt;

    logic                    r_pend_i;
    logic [ADDR_WIDTH-1:0]   r_pend_i_addr;
    logic                    r_pend_d;
    logic                    r_pend_d_rw;
    logic [ADDR_WIDTH-1:0]   r_pend_d_addr;
    logic [DATA_WIDTH-1:0]   r_pend_d_wdata;
    logic [DATA_WIDTH/8-1:0] r_pend_d_ben;

    logic                    w_idle;
    logic                    w_req_i;
    logic                    w_req_d;
    logic                    w_win_i;
    logic                    w_win_d;
    logic                    w_busy_i;
    logic                    w_busy_d;
    logic [c_cnt_w-1:0]      w_cnt_next;
    logic                    w_timeout;
    logic [ADDR_WIDTH-1:0]   w_i_addr;
    logic                    w_d_rw;
    logic [ADDR_WIDTH-1:0]   w_d_addr;
    logic [DATA_WIDTH-1:0]   w_d_wdata;
    logic [DATA_WIDTH/8-1:0] w_d_ben;

    assign w_idle   = (r_state == c_st_idle);
    // A live strobe counts as a request in the same edge it arrives.
    assign w_req_i  = r_pend_i | ibus_stb_i;
    assign w_req_d  = r_pend_d | dbus_stb_i;
    // On a tie the port that was not granted last time wins.
    assign w_win_d  = w_idle & w_req_d & (~w_req_i | ~r_last_d);
    assign w_win_i  = w_idle & w_req_i & ~w_win_d;
    assign w_busy_i = (r_state == c_st_bus) & ~r_gnt_d;
    assign w_busy_d = (r_state == c_st_bus) &  r_gnt_d;

    // A pending slot takes precedence over a live strobe.
    assign w_i_addr  = r_pend_i ? r_pend_i_addr  : ibus_addr_i;
    assign w_d_rw    = r_pend_d ? r_pend_d_rw    : dbus_rw_i;
    assign w_d_addr  = r_pend_d ? r_pend_d_addr  : dbus_addr_i;
    assign w_d_wdata = r_pend_d ? r_pend_d_wdata : dbus_wdata_i;
    assign w_d_ben   = r_pend_d ? r_pend_d_ben   : dbus_ben_i;

    assign w_cnt_next = r_cnt + c_cnt_w'(1);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == c_cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_last_d       <= 1'b0;
            r_gnt_d        <= 1'b0;
            r_cnt          <= '0;
            r_pend_i       <= 1'b0;
            r_pend_i_addr  <= '0;
            r_pend_d       <= 1'b0;
            r_pend_d_rw    <= 1'b0;
            r_pend_d_addr  <= '0;
            r_pend_d_wdata <= '0;
            r_pend_d_ben   <= '0;
            ibus_rdata_o   <= '0;
            ibus_ack_o     <= 1'b0;
            ibus_err_o     <= 1'b0;
            dbus_rdata_o   <= '0;
            dbus_ack_o     <= 1'b0;
            dbus_err_o     <= 1'b0;
            core_cyc_o     <= 1'b0;
            core_stb_o     <= 1'b0;
            core_we_o      <= 1'b0;
            core_wstrb_o   <= '0;
            core_addr_o    <= '0;
            core_data_o    <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            ibus_rdata_o <= '0;
            ibus_ack_o   <= 1'b0;
            ibus_err_o   <= 1'b0;
            dbus_rdata_o <= '0;
            dbus_ack_o   <= 1'b0;
            dbus_err_o   <= 1'b0;

            // Pending capture; a strobe granted in the same edge is not stored.
            if (w_win_i) begin
                r_pend_i <= 1'b0;
            end else if (ibus_stb_i && !r_pend_i && !w_busy_i) begin
                r_pend_i      <= 1'b1;
                r_pend_i_addr <= ibus_addr_i;
            end

            if (w_win_d) begin
                r_pend_d <= 1'b0;
            end else if (dbus_stb_i && !r_pend_d && !w_busy_d) begin
                r_pend_d       <= 1'b1;
                r_pend_d_rw    <= dbus_rw_i;
                r_pend_d_addr  <= dbus_addr_i;
                r_pend_d_wdata <= dbus_wdata_i;
                r_pend_d_ben   <= dbus_ben_i;
            end

            if (r_state == c_st_idle) begin
                if (w_win_i || w_win_d) begin
                    r_state    <= c_st_bus;
                    r_gnt_d    <= w_win_d;
                    r_last_d   <= w_win_d;
                    r_cnt      <= '0;
                    core_cyc_o <= 1'b1;
                    core_stb_o <= 1'b1;
                    if (w_win_d) begin
                        core_we_o    <= w_d_rw;
                        core_wstrb_o <= w_d_ben;
                        core_addr_o  <= w_d_addr;
                        core_data_o  <= w_d_wdata;
                    end else begin
                        core_we_o    <= 1'b0;
                        core_wstrb_o <= '1;
                        core_addr_o  <= w_i_addr;
                        core_data_o  <= '0;
                    end
                end
            end else begin
                if (core_ack_i || w_timeout) begin
                    r_state      <= c_st_idle;
                    core_cyc_o   <= 1'b0;
                    core_stb_o   <= 1'b0;
                    core_we_o    <= 1'b0;
                    core_wstrb_o <= '0;
                    core_addr_o  <= '0;
                    core_data_o  <= '0;
                    // An ack arriving in the timeout cycle still completes normally.
                    if (core_ack_i) begin
                        if (r_gnt_d) begin
                            dbus_ack_o   <= 1'b1;
                            dbus_rdata_o <= core_we_o ? '0 : core_data_i;
                        end else begin
                            ibus_ack_o   <= 1'b1;
                            ibus_rdata_o <= core_data_i;
                        end
                    end else begin
                        if (r_gnt_d) begin
                            dbus_err_o <= 1'b1;
                        end else begin
                            ibus_err_o <= 1'b1;
                        end
                    end
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neorv32_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neorv32_wb_bus_arbiter
//  Purpose  : Directed scoreboard bench for neorv32_wb_bus_arbiter. Expected
//             Wishbone requests and CPU responses are queued when the stimulus
//             is issued, and a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neorv32_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ibus_stb_i = 1'b0;
    logic [AW-1:0] ibus_addr_i = '0;
    logic [DW-1:0] ibus_rdata_o;
    logic          ibus_ack_o;
    logic          ibus_err_o;
    logic          dbus_stb_i = 1'b0;
    logic          dbus_rw_i = 1'b0;
    logic [AW-1:0] dbus_addr_i = '0;
    logic [DW-1:0] dbus_wdata_i = '0;
    logic [BW-1:0] dbus_ben_i = '0;
    logic [DW-1:0] dbus_rdata_o;
    logic          dbus_ack_o;
    logic          dbus_err_o;
    logic          core_cyc_o;
    logic          core_stb_o;
    logic          core_we_o;
    logic [BW-1:0] core_wstrb_o;
    logic [AW-1:0] core_addr_o;
    logic [DW-1:0] core_data_o;
    logic [DW-1:0] core_data_i = '0;
    logic          core_ack_i = 1'b0;

    neorv32_wb_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_stb_i   (ibus_stb_i),
        .ibus_addr_i  (ibus_addr_i),
        .ibus_rdata_o (ibus_rdata_o),
        .ibus_ack_o   (ibus_ack_o),
        .ibus_err_o   (ibus_err_o),
        .dbus_stb_i   (dbus_stb_i),
        .dbus_rw_i    (dbus_rw_i),
        .dbus_addr_i  (dbus_addr_i),
        .dbus_wdata_i (dbus_wdata_i),
        .dbus_ben_i   (dbus_ben_i),
        .dbus_rdata_o (dbus_rdata_o),
        .dbus_ack_o   (dbus_ack_o),
        .dbus_err_o   (dbus_err_o),
        .core_cyc_o   (core_cyc_o),
        .core_stb_o   (core_stb_o),
        .core_we_o    (core_we_o),
        .core_wstrb_o (core_wstrb_o),
        .core_addr_o  (core_addr_o),
        .core_data_o  (core_data_o),
        .core_data_i  (core_data_i),
        .core_ack_i   (core_ack_i)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic          we;
        logic [BW-1:0] wstrb;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    typedef struct {
        logic          is_d;
        logic          err;
        logic [DW-1:0] rdata;
        int            due;    // cycle of the response, -1 = not checked
    } rsp_t;

    wb_t  exp_wb[$];
    rsp_t exp_rsp[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cycle);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- slave model ----------------
    logic slave_mute = 1'b0;
    logic stray_ack  = 1'b0;
    int   slave_wait = 0;
    int   wait_cnt   = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0200: return 32'hCAFE_0000;
            default:       return {a[15:0], 16'hA5A5};
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            core_ack_i  = 1'b0;
            core_data_i = '0;
            if (core_cyc_o && !slave_mute) begin
                if (wait_cnt >= slave_wait) begin
                    core_ack_i  = 1'b1;
                    core_data_i = core_we_o ? 32'h0BAD_0BAD : mem_rd(core_addr_o);
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (!core_cyc_o && stray_ack) begin
                    core_ack_i  = 1'b1;
                    core_data_i = 32'hFFFF_FFFF;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic rsp_chk(input logic is_d, input logic ack, input logic err, input logic [DW-1:0] rdata);
        rsp_t r;
        check(is_d ? "d_ack_err_excl" : "i_ack_err_excl", {31'd0, ack & err}, 32'd0);
        if (ack || err) begin
            check("rsp_expected", {31'd0, exp_rsp.size() != 0}, 32'd1);
            if (exp_rsp.size() != 0) begin
                r = exp_rsp.pop_front();
                check("rsp_port", {31'd0, is_d}, {31'd0, r.is_d});
                check("rsp_err", {31'd0, err}, {31'd0, r.err});
                check("rsp_rdata", rdata, r.rdata);
                check("rsp_cyc_low", {31'd0, core_cyc_o}, 32'd0);
                if (r.due >= 0) check("rsp_latency", cycle, r.due);
            end
        end else begin
            check(is_d ? "d_rdata_idle_zero" : "i_rdata_idle_zero", rdata, 32'd0);
        end
    endtask

    initial begin
        logic prev_cyc;
        wb_t  cur;
        prev_cyc = 1'b0;
        cur = '{1'b0, '0, '0, '0};
        forever begin
            @(negedge clk);
            check("stb_eq_cyc", {31'd0, core_stb_o}, {31'd0, core_cyc_o});
            if (core_cyc_o && !prev_cyc) begin
                check("cyc_expected", {31'd0, exp_wb.size() != 0}, 32'd1);
                if (exp_wb.size() != 0) cur = exp_wb.pop_front();
            end
            if (core_cyc_o) begin
                check("wb_we",    {31'd0, core_we_o},    {31'd0, cur.we});
                check("wb_wstrb", {28'd0, core_wstrb_o}, {28'd0, cur.wstrb});
                check("wb_addr",  core_addr_o,           cur.addr);
                check("wb_data",  core_data_o,           cur.data);
            end else begin
                check("idle_bus_zero", {31'd0, |{core_we_o, core_wstrb_o, core_addr_o, core_data_o}}, 32'd0);
            end
            rsp_chk(1'b0, ibus_ack_o, ibus_err_o, ibus_rdata_o);
            rsp_chk(1'b1, dbus_ack_o, dbus_err_o, dbus_rdata_o);
            prev_cyc = core_cyc_o;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_wb.size() != 0 || exp_rsp.size() != 0 || core_cyc_o) && t < budget) begin
            tick(1);
            t++;
        end
        tick(1);
        check(name, exp_wb.size() + exp_rsp.size(), 32'd0);
        exp_wb.delete();
        exp_rsp.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},   {31'd0, core_cyc_o}, 32'd0);
        check({tag, "_stb"},   {31'd0, core_stb_o}, 32'd0);
        check({tag, "_wbout"}, {31'd0, |{core_we_o, core_wstrb_o, core_addr_o, core_data_o}}, 32'd0);
        check({tag, "_ibus"},  {31'd0, |{ibus_ack_o, ibus_err_o, ibus_rdata_o}}, 32'd0);
        check({tag, "_dbus"},  {31'd0, |{dbus_ack_o, dbus_err_o, dbus_rdata_o}}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic clear_i();
        ibus_stb_i = 1'b0; ibus_addr_i = '0;
    endtask

    task automatic clear_d();
        dbus_stb_i = 1'b0; dbus_rw_i = 1'b0; dbus_addr_i = '0; dbus_wdata_i = '0; dbus_ben_i = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_all_zero("reset");

        // Single dbus write, slave acks one cycle late.
        slave_wait = 1;
        exp_wb.push_back('{1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
        exp_rsp.push_back('{1'b1, 1'b0, 32'h0, cycle + 1 + 2});
        dbus_stb_i = 1'b1; dbus_rw_i = 1'b1; dbus_addr_i = 32'h100;
        dbus_wdata_i = 32'hDEAD_BEEF; dbus_ben_i = 4'b0011;
        tick(1);
        clear_d();
        wait_done("dbus_write_done", 30);

        // Simultaneous reads after reset: dbus first, then ibus.
        do_reset();
        slave_wait = 0;
        exp_wb.push_back('{1'b0, 4'b1100, 32'h200, 32'h1111_2222});
        exp_wb.push_back('{1'b0, 4'b1111, 32'h0,   32'h0});
        exp_rsp.push_back('{1'b1, 1'b0, 32'hCAFE_0000, cycle + 1 + 1});
        exp_rsp.push_back('{1'b0, 1'b0, 32'h0000_0013, cycle + 1 + 3});
        ibus_stb_i = 1'b1; ibus_addr_i = 32'h0;
        dbus_stb_i = 1'b1; dbus_rw_i = 1'b0; dbus_addr_i = 32'h200;
        dbus_wdata_i = 32'h1111_2222; dbus_ben_i = 4'b1100;
        tick(1);
        clear_i();
        clear_d();
        wait_done("tie_done", 30);

        // Round-robin with both ports re-requesting immediately after each ack.
        for (int k = 0; k < 3; k++) begin
            exp_wb.push_back('{1'b0, 4'b1111, 32'h2000 + 4 * k, 32'h0});
            exp_wb.push_back('{1'b0, 4'b1111, 32'h1000 + 4 * k, 32'h0});
            exp_rsp.push_back('{1'b1, 1'b0, mem_rd(32'h2000 + 4 * k), -1});
            exp_rsp.push_back('{1'b0, 1'b0, mem_rd(32'h1000 + 4 * k), -1});
        end
        fork
            begin
                for (int ki = 0; ki < 3; ki++) begin
                    int t;
                    ibus_stb_i = 1'b1; ibus_addr_i = 32'h1000 + 4 * ki;
                    tick(1);
                    clear_i();
                    t = 0;
                    while (!(ibus_ack_o || ibus_err_o) && t < 40) begin tick(1); t++; end
                    check("rr_ibus_ack_seen", {31'd0, t < 40}, 32'd1);
                end
            end
            begin
                for (int kd = 0; kd < 3; kd++) begin
                    int t;
                    dbus_stb_i = 1'b1; dbus_rw_i = 1'b0; dbus_addr_i = 32'h2000 + 4 * kd;
                    dbus_wdata_i = '0; dbus_ben_i = 4'b1111;
                    tick(1);
                    clear_d();
                    t = 0;
                    while (!(dbus_ack_o || dbus_err_o) && t < 40) begin tick(1); t++; end
                    check("rr_dbus_ack_seen", {31'd0, t < 40}, 32'd1);
                end
            end
        join
        wait_done("rr_done", 30);

        // Stray slave acks while idle must not produce any response.
        stray_ack = 1'b1;
        tick(3);
        stray_ack = 1'b0;
        tick(1);

        // Timeout on an ibus read, then a normal dbus read.
        slave_mute = 1'b1;
        exp_wb.push_back('{1'b0, 4'b1111, 32'h300, 32'h0});
        exp_rsp.push_back('{1'b0, 1'b1, 32'h0, cycle + 1 + TO});
        ibus_stb_i = 1'b1; ibus_addr_i = 32'h300;
        tick(1);
        clear_i();
        wait_done("timeout_done", 40);
        slave_mute = 1'b0;
        exp_wb.push_back('{1'b0, 4'b1111, 32'h400, 32'h0});
        exp_rsp.push_back('{1'b1, 1'b0, 32'h0400_A5A5, cycle + 1 + 1});
        dbus_stb_i = 1'b1; dbus_rw_i = 1'b0; dbus_addr_i = 32'h400; dbus_ben_i = 4'b1111;
        tick(1);
        clear_d();
        wait_done("after_timeout_done", 30);

        // dbus write arrives while an ibus read is in flight.
        slave_wait = 2;
        exp_wb.push_back('{1'b0, 4'b1111, 32'h500, 32'h0});
        exp_wb.push_back('{1'b1, 4'b1111, 32'h600, 32'h1234_5678});
        exp_rsp.push_back('{1'b0, 1'b0, 32'h0500_A5A5, cycle + 1 + 3});
        exp_rsp.push_back('{1'b1, 1'b0, 32'h0,         cycle + 2 + 6});
        ibus_stb_i = 1'b1; ibus_addr_i = 32'h500;
        tick(1);
        clear_i();
        dbus_stb_i = 1'b1; dbus_rw_i = 1'b1; dbus_addr_i = 32'h600;
        dbus_wdata_i = 32'h1234_5678; dbus_ben_i = 4'b1111;
        tick(1);
        clear_d();
        wait_done("inflight_done", 40);

        // Reset mid-transaction with an ibus request pending.
        slave_mute = 1'b1;
        slave_wait = 0;
        exp_wb.push_back('{1'b0, 4'b1111, 32'h700, 32'hAAAA_5555});
        dbus_stb_i = 1'b1; dbus_rw_i = 1'b0; dbus_addr_i = 32'h700;
        dbus_wdata_i = 32'hAAAA_5555; dbus_ben_i = 4'b1111;
        tick(1);
        clear_d();
        ibus_stb_i = 1'b1; ibus_addr_i = 32'h800;
        tick(1);
        clear_i();
        tick(1);
        check("midbus_cyc_high", {31'd0, core_cyc_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc", {31'd0, core_cyc_o}, 32'd0);
        check("async_rst_stb", {31'd0, core_stb_o}, 32'd0);
        slave_mute = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_all_zero("post_reset");
        wait_done("post_reset_done", 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
